// File: rtl/network_rr_arbiter.sv
// network_rr_arbiter: round-robin merge of NUM_PORTS streams into one registered stream with burst lock (optional NETWORK_RR_ARBITER_SRC_TAG_EN adds m_src)
module network_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IN_WIDTH  = 32,
  parameter int ID_WIDTH  = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS*ID_WIDTH-1:0] s_id,
  input  logic [NUM_PORTS*IN_WIDTH-1:0] s_val,
  input  logic [NUM_PORTS-1:0]          s_valid,
  output logic [NUM_PORTS-1:0]          s_ready,
  output logic [ID_WIDTH-1:0]           m_id,
  output logic [IN_WIDTH-1:0]           m_val,
  output logic                          m_valid,
`ifdef NETWORK_RR_ARBITER_SRC_TAG_EN
  output logic [$clog2(NUM_PORTS)-1:0]  m_src,
`endif
  input  logic                          m_ready
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, LOCK} state_e;
  state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, owner_q, owner_d, sel, idle_sel, idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ID_WIDTH-1:0] m_id_q, m_id_d;
  logic [IN_WIDTH-1:0] m_val_q, m_val_d;
  logic m_valid_q, m_valid_d;
  logic load, any_valid, owner_ok, xfer;
`ifdef NETWORK_RR_ARBITER_SRC_TAG_EN
  logic [PW-1:0] m_src_q, m_src_d;
  assign m_src = m_src_q;
`endif

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (int'(p) == NUM_PORTS - 1) ? '0 : p + 1'b1;
  endfunction

  assign load      = !m_valid_q || m_ready;
  assign any_valid = |s_valid;
  assign owner_ok  = state_q == LOCK && s_valid[owner_q];
  assign sel       = owner_ok ? owner_q : idle_sel;
  assign xfer      = load && any_valid;
  assign s_ready   = (xfer && !rst) ? NUM_PORTS'(1) << sel : '0;
  assign m_id      = m_id_q;
  assign m_val     = m_val_q;
  assign m_valid   = m_valid_q;

  // first valid port at or after ptr, descending scan so the nearest one wins
  always_comb begin
    idle_sel = ptr_q;
    idx      = ptr_q;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr_q) + k) % NUM_PORTS);
      if (s_valid[idx]) idle_sel = idx;
    end
  end

  // burst lock bookkeeping; a stranded lock with nobody requesting releases itself
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (xfer && owner_ok) begin
      if (int'(cnt_q) + 1 == MAX_BURST) begin
        state_d = IDLE;
        ptr_d   = nxt(owner_q);
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
    end else if (xfer) begin
      if (MAX_BURST > 1) begin
        state_d = LOCK;
        owner_d = sel;
        cnt_d   = CW'(1);
      end else begin
        state_d = IDLE;
        ptr_d   = nxt(sel);
      end
    end else if (state_q == LOCK && !any_valid) begin
      state_d = IDLE;
      ptr_d   = nxt(owner_q);
      cnt_d   = '0;
    end
  end

  // output slice: load on transfer, bubble when nothing arrives, hold while stalled
  always_comb begin
    m_valid_d = load ? xfer : m_valid_q;
    m_id_d    = xfer ? s_id[sel*ID_WIDTH +: ID_WIDTH] : m_id_q;
    m_val_d   = xfer ? s_val[sel*IN_WIDTH +: IN_WIDTH] : m_val_q;
`ifdef NETWORK_RR_ARBITER_SRC_TAG_EN
    m_src_d   = xfer ? sel : m_src_q;
`endif
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_id_q    <= '0;
      m_val_q   <= '0;
`ifdef NETWORK_RR_ARBITER_SRC_TAG_EN
      m_src_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_id_q    <= m_id_d;
      m_val_q   <= m_val_d;
`ifdef NETWORK_RR_ARBITER_SRC_TAG_EN
      m_src_q   <= m_src_d;
`endif
    end
  end
endmodule
